// File: rtl/csr_satp_write_ctrl_pkg.sv
// Shared types and constants for the SATP CSR write path.
package csr_satp_write_ctrl_pkg;

   localparam logic [1:0] PRIV_LVL_U = 2'b00;
   localparam logic [1:0] PRIV_LVL_S = 2'b01;
   localparam logic [1:0] PRIV_LVL_M = 2'b11;

   localparam logic [3:0] SATP_MODE_OFF  = 4'h0;
   localparam logic [3:0] SATP_MODE_SV39 = 4'h8;

   typedef struct packed {
      logic [3:0]  mode;
      logic [15:0] asid;
      logic [43:0] ppn;
   } satp_t;

   typedef enum logic {
      SATP_IDLE,
      SATP_FLUSH
   } satp_fsm_e;

   function automatic logic satp_write_allowed(
      input logic [1:0] priv,
      input logic       tvm
   );
      logic ok;
      ok = 1'b0;
      unique case (priv)
         PRIV_LVL_M: ok = 1'b1;
         PRIV_LVL_S: ok = ~tvm;
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/csr_satp_write_ctrl_if.sv
// CSR-decode / MMU side bundle of the SATP write handler.
interface csr_satp_write_ctrl_if;

   logic        csr_req_valid_i;
   logic        csr_req_ready_o;
   logic [63:0] csr_wdata_i;
   logic [1:0]  priv_lvl_i;
   logic        mstatus_tvm_i;
   logic        write_access_exception_o;
   logic [63:0] satp_o;
   logic        flush_tlb_o;
   logic        flush_ack_i;
   logic        flush_timeout_o;
   logic        busy_o;

   modport master (
      output csr_req_valid_i,
      output csr_wdata_i,
      output priv_lvl_i,
      output mstatus_tvm_i,
      output flush_ack_i,
      input  csr_req_ready_o,
      input  write_access_exception_o,
      input  satp_o,
      input  flush_tlb_o,
      input  flush_timeout_o,
      input  busy_o
   );

   modport slave (
      input  csr_req_valid_i,
      input  csr_wdata_i,
      input  priv_lvl_i,
      input  mstatus_tvm_i,
      input  flush_ack_i,
      output csr_req_ready_o,
      output write_access_exception_o,
      output satp_o,
      output flush_tlb_o,
      output flush_timeout_o,
      output busy_o
   );

endinterface

// File: rtl/csr_satp_write_ctrl_warl.sv
// WARL legalisation of a SATP write: mode filter and ASID masking.
module csr_satp_write_ctrl_warl
   import csr_satp_write_ctrl_pkg::*;
#(
   parameter int unsigned ASID_WIDTH = 16
) (
   input  logic [63:0] wdata,
   output logic        legal,
   output satp_t       value
);

   satp_t       raw;
   logic [15:0] asid_mask;

   assign raw       = satp_t'(wdata);
   assign asid_mask = 16'((32'h1 << ASID_WIDTH) - 32'h1);

   assign legal = (raw.mode == SATP_MODE_OFF) ||
                  (raw.mode == SATP_MODE_SV39);

   always_comb begin
      value      = raw;
      value.asid = raw.asid & asid_mask;
   end

endmodule

// File: rtl/csr_satp_write_ctrl.sv
// SATP CSR write handler: access check, WARL update, TLB flush handshake.
module csr_satp_write_ctrl
   import csr_satp_write_ctrl_pkg::*;
#(
   parameter int unsigned ASID_WIDTH    = 16,
   parameter int unsigned FLUSH_TIMEOUT = 255
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   csr_satp_write_ctrl_if.slave bus
);

   localparam int unsigned CW =
      (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_TIMEOUT - 1);

   satp_fsm_e     state_q, state_d;
   satp_t         satp_q, satp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          exc_q, exc_d;
   logic          tmo_q, tmo_d;
   logic          accept;
   logic          allowed;
   logic          warl_ok;
   satp_t         warl_val;

   csr_satp_write_ctrl_warl #(
      .ASID_WIDTH (ASID_WIDTH)
   ) u_warl (
      .wdata (bus.csr_wdata_i),
      .legal (warl_ok),
      .value (warl_val)
   );

   assign accept  = bus.csr_req_valid_i && (state_q == SATP_IDLE);
   assign allowed = satp_write_allowed(bus.priv_lvl_i,
                                       bus.mstatus_tvm_i);

   always_comb begin
      state_d = state_q;
      satp_d  = satp_q;
      cnt_d   = cnt_q;
      exc_d   = 1'b0;
      tmo_d   = 1'b0;
      unique case (state_q)
         SATP_IDLE: begin
            if (accept) begin
               if (!allowed) begin
                  exc_d = 1'b1;
               end else if (warl_ok) begin
                  satp_d  = warl_val;
                  cnt_d   = '0;
                  state_d = SATP_FLUSH;
               end
            end
         end
         SATP_FLUSH: begin
            // ack has priority over an expiring timeout
            if (bus.flush_ack_i) begin
               state_d = SATP_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               tmo_d   = 1'b1;
               state_d = SATP_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = SATP_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SATP_IDLE;
         satp_q  <= '0;
         cnt_q   <= '0;
         exc_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         satp_q  <= satp_d;
         cnt_q   <= cnt_d;
         exc_q   <= exc_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.csr_req_ready_o          = (state_q == SATP_IDLE);
   assign bus.write_access_exception_o = exc_q;
   assign bus.satp_o                   = satp_q;
   assign bus.flush_tlb_o              = (state_q == SATP_FLUSH);
   assign bus.busy_o                   = (state_q == SATP_FLUSH);
   assign bus.flush_timeout_o          = tmo_q;

endmodule

// File: tb/tb_csr_satp_write_ctrl.sv
// Directed bench for csr_satp_write_ctrl (ASID_WIDTH=9, FLUSH_TIMEOUT=4).
module tb_csr_satp_write_ctrl;

   logic clk_i;
   logic rst_ni;
   int   n_checks;
   int   n_fail;

   csr_satp_write_ctrl_if bus ();

   csr_satp_write_ctrl #(
      .ASID_WIDTH    (9),
      .FLUSH_TIMEOUT (4)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  priv;
      logic        tvm;
      logic [63:0] wdata;
      logic        exc;
      logic        flush;
      logic [63:0] satp;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] p,
                        input logic t,
                        input logic [63:0] w);
      bus.csr_req_valid_i = 1'b1;
      bus.priv_lvl_i      = p;
      bus.mstatus_tvm_i   = t;
      bus.csr_wdata_i     = w;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus.csr_req_valid_i = 1'b0;
      bus.csr_wdata_i     = '0;
      bus.priv_lvl_i      = 2'b11;
      bus.mstatus_tvm_i   = 1'b0;
      bus.flush_ack_i     = 1'b0;

      tbl[0]  = '{2'b01, 1'b1, 64'h8000_0000_0000_1234,
                  1'b1, 1'b0, 64'h0};
      tbl[1]  = '{2'b00, 1'b0, 64'h8000_0000_0000_1234,
                  1'b1, 1'b0, 64'h0};
      tbl[2]  = '{2'b10, 1'b0, 64'h8000_0000_0000_1234,
                  1'b1, 1'b0, 64'h0};
      tbl[3]  = '{2'b01, 1'b0, 64'h9000_0000_0000_0001,
                  1'b0, 1'b0, 64'h0};
      tbl[4]  = '{2'b11, 1'b1, 64'h8000_0000_0008_0000,
                  1'b0, 1'b1, 64'h8000_0000_0008_0000};
      tbl[5]  = '{2'b11, 1'b0, 64'h8000_0000_0008_0000,
                  1'b0, 1'b1, 64'h8000_0000_0008_0000};
      tbl[6]  = '{2'b01, 1'b0, 64'h8FFF_F000_0000_0001,
                  1'b0, 1'b1, 64'h801F_F000_0000_0001};
      tbl[7]  = '{2'b00, 1'b1, 64'h0000_0000_0000_0000,
                  1'b1, 1'b0, 64'h801F_F000_0000_0001};
      tbl[8]  = '{2'b01, 1'b0, 64'h0000_0000_0000_0000,
                  1'b0, 1'b1, 64'h0};
      tbl[9]  = '{2'b11, 1'b0, 64'hF123_4567_89AB_CDEF,
                  1'b0, 1'b0, 64'h0};
      tbl[10] = '{2'b11, 1'b0, 64'h8ABC_D000_0000_0042,
                  1'b0, 1'b1, 64'h801C_D000_0000_0042};

      rst_ni = 1'b0;
      #12;
      chk("rst_satp", bus.satp_o, 64'h0);
      chk("rst_flush", 64'(bus.flush_tlb_o), 64'h0);
      chk("rst_exc", 64'(bus.write_access_exception_o), 64'h0);
      chk("rst_tmo", 64'(bus.flush_timeout_o), 64'h0);
      chk("rst_busy", 64'(bus.busy_o), 64'h0);
      chk("rst_ready", 64'(bus.csr_req_ready_o), 64'h1);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk_i);
         chk($sformatf("v%0d_ready", i),
             64'(bus.csr_req_ready_o), 64'h1);
         drive(tbl[i].priv, tbl[i].tvm, tbl[i].wdata);
         @(negedge clk_i);
         bus.csr_req_valid_i = 1'b0;
         chk($sformatf("v%0d_exc", i),
             64'(bus.write_access_exception_o), 64'(tbl[i].exc));
         chk($sformatf("v%0d_flush", i),
             64'(bus.flush_tlb_o), 64'(tbl[i].flush));
         chk($sformatf("v%0d_busy", i),
             64'(bus.busy_o), 64'(tbl[i].flush));
         chk($sformatf("v%0d_satp", i), bus.satp_o, tbl[i].satp);
         if (tbl[i].flush) begin
            bus.flush_ack_i = 1'b1;
            @(negedge clk_i);
            bus.flush_ack_i = 1'b0;
            chk($sformatf("v%0d_flush_drop", i),
                64'(bus.flush_tlb_o), 64'h0);
            chk($sformatf("v%0d_ready_back", i),
                64'(bus.csr_req_ready_o), 64'h1);
            chk($sformatf("v%0d_no_tmo", i),
                64'(bus.flush_timeout_o), 64'h0);
         end else begin
            @(negedge clk_i);
            chk($sformatf("v%0d_exc_end", i),
                64'(bus.write_access_exception_o), 64'h0);
            chk($sformatf("v%0d_no_flush", i),
                64'(bus.flush_tlb_o), 64'h0);
         end
      end

      // illegal writes accepted on consecutive cycles
      @(negedge clk_i);
      drive(2'b00, 1'b0, 64'h8000_0000_0000_0001);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk($sformatf("b2b_ill_exc%0d", k),
             64'(bus.write_access_exception_o), 64'h1);
         chk($sformatf("b2b_ill_rdy%0d", k),
             64'(bus.csr_req_ready_o), 64'h1);
      end
      bus.csr_req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("b2b_ill_end", 64'(bus.write_access_exception_o), 64'h0);

      // back-to-back legal writes with immediate ack
      bus.flush_ack_i = 1'b1;
      drive(2'b11, 1'b0, 64'h8000_0000_0000_0111);
      @(negedge clk_i);
      chk("b2b_leg_flush0", 64'(bus.flush_tlb_o), 64'h1);
      chk("b2b_leg_rdy0", 64'(bus.csr_req_ready_o), 64'h0);
      chk("b2b_leg_satp0", bus.satp_o, 64'h8000_0000_0000_0111);
      bus.csr_wdata_i = 64'h8000_0000_0000_0222;
      @(negedge clk_i);
      chk("b2b_leg_flush1", 64'(bus.flush_tlb_o), 64'h0);
      chk("b2b_leg_rdy1", 64'(bus.csr_req_ready_o), 64'h1);
      chk("b2b_leg_satp1", bus.satp_o, 64'h8000_0000_0000_0111);
      @(negedge clk_i);
      bus.csr_req_valid_i = 1'b0;
      chk("b2b_leg_flush2", 64'(bus.flush_tlb_o), 64'h1);
      chk("b2b_leg_satp2", bus.satp_o, 64'h8000_0000_0000_0222);
      @(negedge clk_i);
      bus.flush_ack_i = 1'b0;
      chk("b2b_leg_end", 64'(bus.flush_tlb_o), 64'h0);

      // flush abandoned after four unacknowledged cycles
      drive(2'b11, 1'b0, 64'h8000_0000_0000_0333);
      @(negedge clk_i);
      bus.csr_req_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("tmo_flush%0d", k),
             64'(bus.flush_tlb_o), 64'h1);
         chk($sformatf("tmo_pulse_early%0d", k),
             64'(bus.flush_timeout_o), 64'h0);
         @(negedge clk_i);
      end
      chk("tmo_pulse", 64'(bus.flush_timeout_o), 64'h1);
      chk("tmo_flush_drop", 64'(bus.flush_tlb_o), 64'h0);
      chk("tmo_ready", 64'(bus.csr_req_ready_o), 64'h1);
      @(negedge clk_i);
      chk("tmo_pulse_end", 64'(bus.flush_timeout_o), 64'h0);

      // ack on the same edge as the timeout wins
      drive(2'b11, 1'b0, 64'h8000_0000_0000_0444);
      @(negedge clk_i);
      bus.csr_req_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("race_flush", 64'(bus.flush_tlb_o), 64'h1);
      bus.flush_ack_i = 1'b1;
      @(negedge clk_i);
      bus.flush_ack_i = 1'b0;
      chk("race_no_tmo", 64'(bus.flush_timeout_o), 64'h0);
      chk("race_flush_drop", 64'(bus.flush_tlb_o), 64'h0);
      @(negedge clk_i);
      chk("race_no_tmo_late", 64'(bus.flush_timeout_o), 64'h0);

      // asynchronous reset in the middle of a flush
      drive(2'b11, 1'b0, 64'h8000_0000_0000_0555);
      @(negedge clk_i);
      chk("arst_pre_flush", 64'(bus.flush_tlb_o), 64'h1);
      drive(2'b01, 1'b0, 64'h8000_0000_0000_0666);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_satp", bus.satp_o, 64'h0);
      chk("arst_flush", 64'(bus.flush_tlb_o), 64'h0);
      chk("arst_busy", 64'(bus.busy_o), 64'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      bus.csr_req_valid_i = 1'b0;
      chk("arst_accept_satp", bus.satp_o, 64'h8000_0000_0000_0666);
      chk("arst_accept_flush", 64'(bus.flush_tlb_o), 64'h1);
      bus.flush_ack_i = 1'b1;
      @(negedge clk_i);
      bus.flush_ack_i = 1'b0;
      chk("arst_done", 64'(bus.flush_tlb_o), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_checks, n_fail);
      $finish;
   end

endmodule
